// File: rtl/dsp_mac_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : dsp_mac_sequencer_if
//  Purpose  : Requester-side bundle for the MAC sequencer: job start,
//             operand stream and result stream.
//  Revision : 1.0  initial release
// ============================================================================
interface dsp_mac_sequencer_if #(
    parameter int LEN_W = 8
) ();
    logic             START;
    logic [LEN_W-1:0] LEN;
    logic             BUSY;
    logic             OP_VALID;
    logic             OP_READY;
    logic [17:0]      A_IN;
    logic [17:0]      B_IN;
    logic             RES_VALID;
    logic             RES_READY;
    logic [47:0]      RES_DATA;

    // Requester (filter / dot-product client) side
    modport master (
        output START, LEN, OP_VALID, A_IN, B_IN, RES_READY,
        input  BUSY, OP_READY, RES_VALID, RES_DATA
    );

    // Sequencer side
    modport slave (
        input  START, LEN, OP_VALID, A_IN, B_IN, RES_READY,
        output BUSY, OP_READY, RES_VALID, RES_DATA
    );
endinterface
`default_nettype wire

// File: rtl/dsp_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : dsp_mac_sequencer
//  Purpose  : Drives a DSP48A1-style slice as a multiply-accumulate engine.
//             Accepts LEN operand pairs, steers CE/CEP/RSTP/OPMODE so P ends
//             up holding sum(A_i*B_i), then offers P as a result.
//  Revision : 1.0  initial release
// ============================================================================
module dsp_mac_sequencer #(
    parameter int LAT   = 4,    // slice register stages A/B -> P inclusive, 1..8
    parameter int LEN_W = 8
) (
    input  logic               CLK,
    input  logic               RSTN,
    dsp_mac_sequencer_if.slave req,
    output logic [17:0]        A,
    output logic [17:0]        B,
    output logic               CE,
    output logic               CEP,
    output logic               RSTP,
    output logic [7:0]         OPMODE,
    input  logic [47:0]        P_IN
);

    localparam int          DRN_W      = 4;
    localparam logic [7:0]  C_OP_LOAD  = 8'h01;  // P = M
    localparam logic [7:0]  C_OP_ACCUM = 8'h09;  // P = P + M
    localparam logic [7:0]  C_OP_NONE  = 8'h00;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic [LEN_W-1:0]   r_remaining;
    logic [DRN_W-1:0]   r_drain;
    logic               r_first;
    logic               r_busy;
    logic               r_op_ready;
    logic               r_res_valid;

    logic               w_start_acc;
    logic               w_op_acc;
    logic               w_push_valid;
    logic               w_push_first;
    logic               w_out_valid;
    logic               w_out_first;

    // Operands go straight to the slice; the slice's own A/B registers
    // capture them under CE.
    assign A = req.A_IN;
    assign B = req.B_IN;

    // RSTN gates the start strobe so RSTP stays low while reset is held,
    // even if the requester keeps START high.
    assign w_start_acc = req.START & (r_state == S_IDLE) & RSTN;
    // r_op_ready is high exactly while in LOAD.
    assign w_op_acc    = req.OP_VALID & r_op_ready;

    assign CE   = w_op_acc | (r_state == S_DRAIN);
    assign RSTP = w_start_acc;

    assign w_push_valid = w_op_acc;
    assign w_push_first = r_first;

    // Main sequencer: state, counters and registered handshake outputs.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_drain     <= '0;
            r_first     <= 1'b0;
            r_busy      <= 1'b0;
            r_op_ready  <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req.START) begin
                        r_remaining <= req.LEN;
                        r_first     <= 1'b1;
                        r_busy      <= 1'b1;
                        if (req.LEN == '0) begin
                            r_state     <= S_DONE;
                            r_res_valid <= 1'b1;
                        end else begin
                            r_state    <= S_LOAD;
                            r_op_ready <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_op_acc) begin
                        r_remaining <= r_remaining - 1'b1;
                        r_first     <= 1'b0;
                        if (r_remaining == LEN_W'(1)) begin
                            r_op_ready <= 1'b0;
                            if (LAT > 1) begin
                                r_state <= S_DRAIN;
                                r_drain <= DRN_W'(LAT - 1);
                            end else begin
                                r_state     <= S_DONE;
                                r_res_valid <= 1'b1;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    // Push LAT-1 empty tags so the last product reaches P.
                    r_drain <= r_drain - 1'b1;
                    if (r_drain == DRN_W'(1)) begin
                        r_state     <= S_DONE;
                        r_res_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (req.RES_READY) begin
                        r_state     <= S_IDLE;
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Tag pipeline mirrors the slice's pre-P stages so the P-stage
    // controls line up with the product currently sitting in M.
    if (LAT > 1) begin : g_tag_pipe
        logic [LAT-2:0] r_tag_valid;
        logic [LAT-2:0] r_tag_first;

        // Shift tags only when the slice pipeline advances.
        always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
                r_tag_valid <= '0;
                r_tag_first <= '0;
            end else if (CE) begin
                r_tag_valid[0] <= w_push_valid;
                r_tag_first[0] <= w_push_valid & w_push_first;
                for (int i = 1; i < LAT - 1; i++) begin
                    r_tag_valid[i] <= r_tag_valid[i-1];
                    r_tag_first[i] <= r_tag_first[i-1];
                end
            end
        end

        assign w_out_valid = r_tag_valid[LAT-2];
        assign w_out_first = r_tag_first[LAT-2];
    end else begin : g_tag_bypass
        assign w_out_valid = w_push_valid;
        assign w_out_first = w_push_valid & w_push_first;
    end

    assign CEP = CE & w_out_valid;

    // P-stage function selected by the tag of the product leaving M.
    always_comb begin
        OPMODE = C_OP_NONE;
        if (w_out_valid) begin
            OPMODE = w_out_first ? C_OP_LOAD : C_OP_ACCUM;
        end
    end

    assign req.BUSY      = r_busy;
    assign req.OP_READY  = r_op_ready;
    assign req.RES_VALID = r_res_valid;
    assign req.RES_DATA  = P_IN;

endmodule
`default_nettype wire

// File: tb/tb_dsp_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dsp_mac_sequencer
//  Purpose  : Self-checking bench for dsp_mac_sequencer with LAT=4 and LAT=1
//             instances, each attached to a behavioural slice model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dsp_mac_sequencer;

    logic CLK  = 1'b0;
    logic RSTN = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_ce  = 0;
    int n_cep = 0;

    // Stimulus variables
    logic        sel     = 1'b0;   // 0: LAT=4 instance, 1: LAT=1 instance
    logic        t_start = 1'b0;
    logic [7:0]  t_len   = 8'd0;
    logic        t_opv   = 1'b0;
    logic [17:0] t_a     = '0;
    logic [17:0] t_b     = '0;
    logic        t_rdy   = 1'b0;

    logic signed [17:0] op_a [16];
    logic signed [17:0] op_b [16];
    int                 gap  [16];

    dsp_mac_sequencer_if #(.LEN_W(8)) if4 ();
    dsp_mac_sequencer_if #(.LEN_W(8)) if1 ();

    logic [17:0] a4, b4, a1, b1;
    logic        ce4, cep4, rstp4, ce1, cep1, rstp1;
    logic [7:0]  opm4, opm1;
    logic [47:0] p4, p1;

    assign if4.START     = ~sel & t_start;
    assign if4.LEN       = t_len;
    assign if4.OP_VALID  = ~sel & t_opv;
    assign if4.A_IN      = t_a;
    assign if4.B_IN      = t_b;
    assign if4.RES_READY = ~sel & t_rdy;
    assign if1.START     = sel & t_start;
    assign if1.LEN       = t_len;
    assign if1.OP_VALID  = sel & t_opv;
    assign if1.A_IN      = t_a;
    assign if1.B_IN      = t_b;
    assign if1.RES_READY = sel & t_rdy;

    dsp_mac_sequencer #(.LAT(4), .LEN_W(8)) u_dut4 (
        .CLK(CLK), .RSTN(RSTN), .req(if4), .A(a4), .B(b4), .CE(ce4),
        .CEP(cep4), .RSTP(rstp4), .OPMODE(opm4), .P_IN(p4)
    );
    dsp_mac_sequencer #(.LAT(1), .LEN_W(8)) u_dut1 (
        .CLK(CLK), .RSTN(RSTN), .req(if1), .A(a1), .B(b1), .CE(ce1),
        .CEP(cep1), .RSTP(rstp1), .OPMODE(opm1), .P_IN(p1)
    );

    // ---------------- behavioural slice models ----------------
    function automatic logic [47:0] prod(input logic [17:0] a, input logic [17:0] b);
        logic signed [35:0] m;
        m = $signed(a) * $signed(b);
        return {{12{m[35]}}, m};
    endfunction

    function automatic logic [47:0] p_next(input logic [47:0] p, input logic [47:0] m,
                                           input logic rstp, input logic cep,
                                           input logic [7:0] opm);
        if (rstp)           return 48'd0;
        if (!cep)           return p;
        if (opm == 8'h01)   return m;
        if (opm == 8'h09)   return p + m;
        return 48'd0;
    endfunction

    // LAT=4 slice: three pre-P stages modelled as a product pipe, then P.
    logic [47:0] m4_pipe [3];
    always_ff @(posedge CLK) begin
        if (ce4) begin
            m4_pipe[0] <= prod(a4, b4);
            m4_pipe[1] <= m4_pipe[0];
            m4_pipe[2] <= m4_pipe[1];
        end
        p4 <= p_next(p4, m4_pipe[2], rstp4, cep4, opm4);
    end

    // LAT=1 slice: the product feeds P directly.
    always_ff @(posedge CLK) begin
        p1 <= p_next(p1, prod(a1, b1), rstp1, cep1, opm1);
    end

    // Observed outputs of the selected instance
    logic        w_busy, w_opr, w_ce, w_cep, w_rstp, w_resv;
    logic [7:0]  w_opm;
    logic [47:0] w_data;
    assign w_busy = sel ? if1.BUSY      : if4.BUSY;
    assign w_opr  = sel ? if1.OP_READY  : if4.OP_READY;
    assign w_ce   = sel ? ce1           : ce4;
    assign w_cep  = sel ? cep1          : cep4;
    assign w_rstp = sel ? rstp1         : rstp4;
    assign w_resv = sel ? if1.RES_VALID : if4.RES_VALID;
    assign w_opm  = sel ? opm1          : opm4;
    assign w_data = sel ? if1.RES_DATA  : if4.RES_DATA;

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Every P update must load on the first product of a job and
    // accumulate on every later one.
    always @(negedge CLK) begin
        if (RSTN) begin
            if (w_ce) n_ce++;
            if (w_cep) begin
                chk("opmode", 64'(w_opm), (n_cep == 0) ? 64'h01 : 64'h09);
                n_cep++;
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    // Runs one job on the selected instance using op_a/op_b/gap, holds
    // RES_READY low for `hold` DONE cycles (optionally poking START).
    task automatic run_job(input int len, input int hold, input bit poke);
        longint      acc;
        logic [47:0] exp48;
        int          lat;
        int          last_acc;
        int          k;
        acc = 0;
        for (int i = 0; i < len; i++) acc += longint'(op_a[i]) * longint'(op_b[i]);
        exp48 = acc[47:0];
        lat   = sel ? 1 : 4;

        step();
        t_start = 1'b1; t_len = 8'(len); n_ce = 0; n_cep = 0;
        @(negedge CLK);
        chk("rstp_on_start", 64'(w_rstp), 64'd1);
        chk("busy_in_idle", 64'(w_busy), 64'd0);
        last_acc = cyc;

        for (int i = 0; i < len; i++) begin
            for (int g = 0; g < gap[i]; g++) begin
                step();
                t_start = 1'b0; t_opv = 1'b0;
                @(negedge CLK);
                chk("ce_in_gap", 64'(w_ce), 64'd0);
            end
            step();
            t_start = 1'b0; t_opv = 1'b1; t_a = op_a[i]; t_b = op_b[i];
            @(negedge CLK);
            chk("op_ready", 64'(w_opr), 64'd1);
            last_acc = cyc;
        end

        step();
        t_start = 1'b0; t_opv = 1'b0;
        k = 0;
        forever begin
            @(negedge CLK);
            if (w_resv || k == 20) break;
            step();
            k++;
        end
        chk("res_valid_cycle", w_resv ? 64'(cyc) : 64'hFFFF,
            (len == 0) ? 64'(last_acc + 1) : 64'(last_acc + lat));

        for (int h = 0; h < hold; h++) begin
            step();
            t_start = poke; t_len = 8'd5;
            @(negedge CLK);
            chk("hold_valid", 64'(w_resv), 64'd1);
            chk("hold_busy", 64'(w_busy), 64'd1);
            chk("hold_data", 64'(w_data), 64'(exp48));
        end

        step();
        t_start = 1'b0; t_rdy = 1'b1;
        @(negedge CLK);
        chk("res_data", 64'(w_data), 64'(exp48));
        chk("res_valid_hs", 64'(w_resv), 64'd1);

        step();
        t_rdy = 1'b0;
        @(negedge CLK);
        chk("idle_after_hs", 64'(w_busy), 64'd0);
        chk("valid_after_hs", 64'(w_resv), 64'd0);
        chk("cep_count", 64'(n_cep), 64'(len));
        chk("ce_count", 64'(n_ce), (len == 0) ? 64'd0 : 64'(len + lat - 1));
    endtask

    task automatic clear_gaps();
        for (int i = 0; i < 16; i++) gap[i] = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_gaps();
        t_start = 1'b1;  // must be ignored while reset is held
        step(); step();
        @(negedge CLK);
        chk("rst_busy4", 64'(if4.BUSY), 64'd0);
        chk("rst_opready4", 64'(if4.OP_READY), 64'd0);
        chk("rst_ce4", 64'(ce4), 64'd0);
        chk("rst_rstp4", 64'(rstp4), 64'd0);
        chk("rst_opmode4", 64'(opm4), 64'd0);
        chk("rst_resv4", 64'(if4.RES_VALID), 64'd0);
        chk("rst_busy1", 64'(if1.BUSY), 64'd0);
        chk("rst_cep1", 64'(cep1), 64'd0);
        step();
        t_start = 1'b0; RSTN = 1'b1;

        // Back-to-back job on LAT=4
        sel = 1'b0;
        op_a[0] = 18'sd2;  op_b[0] = 18'sd3;
        op_a[1] = 18'sd4;  op_b[1] = 18'sd5;
        op_a[2] = -18'sd1; op_b[2] = 18'sd6;
        run_job(3, 0, 1'b0);

        // Same job with a two-cycle stall after the first pair
        gap[1] = 2;
        run_job(3, 0, 1'b0);
        clear_gaps();

        // Leave 0x123 in P, then an empty job must clear it
        op_a[0] = 18'sd3; op_b[0] = 18'sd97;
        run_job(1, 0, 1'b0);
        run_job(0, 0, 1'b0);

        // Back-pressure with START pulsed during DONE
        op_a[0] = 18'sd2; op_b[0] = 18'sd3;
        op_a[1] = 18'sd4; op_b[1] = 18'sd5;
        run_job(2, 5, 1'b1);

        // Reset during DRAIN
        step();
        t_start = 1'b1; t_len = 8'd3;
        for (int i = 0; i < 3; i++) begin
            step();
            t_start = 1'b0; t_opv = 1'b1; t_a = 18'd9; t_b = 18'd9;
        end
        step();
        t_opv = 1'b0;
        #1;
        RSTN = 1'b0; t_start = 1'b1;
        @(negedge CLK);
        chk("midrst_busy", 64'(w_busy), 64'd0);
        chk("midrst_opready", 64'(w_opr), 64'd0);
        chk("midrst_ce", 64'(w_ce), 64'd0);
        chk("midrst_cep", 64'(w_cep), 64'd0);
        chk("midrst_rstp", 64'(w_rstp), 64'd0);
        chk("midrst_opmode", 64'(w_opm), 64'd0);
        chk("midrst_resv", 64'(w_resv), 64'd0);
        step();
        t_start = 1'b0; RSTN = 1'b1;
        op_a[0] = 18'sd7; op_b[0] = 18'sd7;
        op_a[1] = 18'sd1; op_b[1] = 18'sd1;
        run_job(2, 0, 1'b0);

        // No pipeline: LAT=1
        sel = 1'b1;
        op_a[0] = 18'sd3; op_b[0] = 18'sd3;
        op_a[1] = 18'sd2; op_b[1] = -18'sd2;
        run_job(2, 0, 1'b0);

        // Randomized jobs on both instances
        for (int j = 0; j < 40; j++) begin
            int len;
            sel = 1'($urandom_range(0, 1));
            len = $urandom_range(0, 7);
            for (int i = 0; i < 16; i++) begin
                op_a[i] = 18'($urandom);
                op_b[i] = 18'($urandom);
                gap[i]  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            end
            run_job(len, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dsp_mac_sequencer.md
# dsp_mac_sequencer

Controller that drives one DSP48A1-style slice as a multiply-accumulate engine. It accepts a job of LEN operand pairs over a valid/ready stream and forwards A/B into the slice. It drives the slice pipeline clock-enables, CEP, RSTP and OPMODE so that P ends up holding sum(A_i*B_i), then presents P as a result with a valid/ready handshake. It sits between a requester (filter or dot-product client) and the slice's A/B/P registers. The slice is configured with OPMODEREG=0, and all of its pre-P stages share one CE.

## Interface
- LAT, 4: register stages from the A/B inputs to P inclusive (e.g. A0, A1, M, P); legal range 1..8.
- LEN_W, 8: width of the job length.
- CLK  in  1  clock; all state updates on rising edge.
- RSTN  in  1  asynchronous, active-low reset.
- START  in  1  job request; accepted only in IDLE.
- LEN  in  LEN_W  number of operand pairs; sampled with accepted START.
- BUSY  out  1  high in any state other than IDLE.
- OP_VALID  in  1  operand pair valid.
- OP_READY  out  1  high in LOAD.
- A_IN, B_IN  in  18  operands, signed.
- A, B  out  18  combinational pass-through of A_IN, B_IN to the slice.
- CE  out  1  enable for all slice stages before P (CEA/CEB/CEM).
- CEP  out  1  P-register enable.
- RSTP  out  1  synchronous P clear to the slice, active high.
- OPMODE  out  8  slice OPMODE.
- P_IN  in  48  slice P output.
- RES_VALID  out  1  result valid; high in DONE.
- RES_READY  in  1  result consumer ready.
- RES_DATA  out  48  equals P_IN; meaningful only while RES_VALID=1.

## Operation
- States are IDLE, LOAD, DRAIN and DONE.
- IDLE:
  - START accept = START & IDLE.
  - On accept: RSTP=1 combinationally that cycle, and the remaining counter loads LEN.
  - Next state is DONE if LEN=0, else LOAD.
- LOAD:
  - OP_READY=1. Operand accept = OP_VALID & OP_READY. CE = accept.
  - Each accept decrements the remaining counter and pushes a tag {valid=1, first} into the tag shift register. first=1 only for the first pair of the job.
  - When the accept occurs with remaining=1, the next state is DRAIN if LAT>1, else DONE.
- Tag shift register:
  - LAT-1 entries, advances only when CE=1; an invalid tag is pushed during DRAIN.
  - Output tag is the last entry, or the pushed tag directly when LAT=1.
- P-stage control:
  - CEP = CE & output.valid.
  - OPMODE = 8'h01 (P=M) when output.first, 8'h09 (P=P+M) when valid & !first, 8'h00 otherwise.
- DRAIN: CE=1 for exactly LAT-1 cycles (drain counter), no operand accept, then DONE.
- DONE:
  - RES_VALID=1. CE=0, CEP=0 and RSTP=0, so P holds.
  - On RES_VALID & RES_READY, the next state is IDLE.
- START outside IDLE is ignored; no queueing.
- OP_VALID outside LOAD is ignored (OP_READY=0).
- Arithmetic width and overflow belong to the slice; the controller does no arithmetic beyond its counters.
- Reset:
  - RSTN low immediately forces IDLE, clears the counters and all tags, and drives BUSY=0, OP_READY=0, CE=0, CEP=0, RSTP=0, OPMODE=8'h00, RES_VALID=0.
  - Slice P contents are not cleared by reset; the next START's RSTP pulse clears them.

## Timing
- Operand accepted in cycle c is captured in the first slice stage at the end of c. Its product enters P at the end of the cycle in which its tag is at the output. With no stalls that is cycle c+LAT-1.
- Stalls (OP_VALID=0 in LOAD) freeze the whole slice pipeline and the tags. Results are identical with and without gaps.
- Last pair accepted in cycle c: DRAIN covers c+1..c+LAT-1, and RES_VALID=1 from cycle c+LAT.
- LEN=0: START in cycle s, RSTP=1 in s, RES_VALID=1 from s+1 with P_IN=0.
- Earliest next START accept is the cycle after the RES handshake.
- No combinational path from RES_READY or OP_VALID to BUSY.

## Test plan
- **Back-to-back job:** LAT=4, LEN=3, pairs (2,3),(4,5),(-1,6) in cycles 1-3 → OPMODE 01,09,09 with CEP=1 in cycles 4,5,6; RES_VALID in cycle 7; RES_DATA=20.
- **Gaps:** same job with OP_VALID low for 2 cycles after the first pair → CE=0 in the gap cycles; RES_VALID in cycle 9; RES_DATA=20.
- **Empty job:** LEN=0 with P previously 0x123 → RSTP=1 for 1 cycle; RES_VALID the next cycle with RES_DATA=0; CE never asserted.
- **Back-pressure:** RES_READY held low 5 cycles in DONE, with START pulsed meanwhile → RES_VALID and RES_DATA stable, BUSY=1, START ignored; IDLE the cycle after RES_READY rises.
- **Reset mid-job:** RSTN low during DRAIN → all outputs at reset values that cycle. After release, LEN=2 with (7,7),(1,1) → RES_DATA=50.
- **No pipeline:** LAT=1, LEN=2 with (3,3),(2,-2) → no DRAIN state; RES_VALID the cycle after the last accept; RES_DATA=5.
